regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameters (name, default, meaning): WIDTH, 32, data width; NREG, 16, architectural registers (r(NREG-1) is PC); NRD, 3, read ports; PEND_MAX, 3, max in-flight writes per register.
REQ-002 AW SHALL be a derived constant equal to clog2(NREG); it is not a user parameter.
REQ-003 clk  in  1  clock; the block SHALL use one clock, all state updating on its rising edge.
REQ-004 reset  in  1  reset; SHALL be synchronous and active-high.
REQ-005 ra  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-006 re  in  NRD  read-port enables; only an enabled port can raise a hazard.
REQ-007 pc8  in  WIDTH  value returned for reads of r(NREG-1).
REQ-008 rd  out  NRD*WIDTH  read data, per-port slices as for ra.
REQ-009 we0, wa0, wd0  in  1/AW/WIDTH  result write port (primary).
REQ-010 we1, wa1, wd1  in  1/AW/WIDTH  base-writeback port (pre/post-index).
REQ-011 iss_en, iss_wa  in  1/AW  issue: instruction entering execute claims iss_wa.
REQ-012 iss_rdy  out  1  issue accepted this cycle.
REQ-013 flush  in  1  discard all pending claims.
REQ-014 hazard  out  1  at least one enabled read targets a register with an unresolved pending write.

Function
REQ-015 Reads SHALL be combinational; ra = NREG-1 returns pc8; otherwise stored value.
REQ-016 Writes SHALL commit on the rising edge; writes to r(NREG-1) SHALL be ignored.
REQ-017 If we0 and we1 target the same register in the same cycle, wd0 SHALL win.
REQ-018 Each register except the PC SHALL hold a pending count 0..PEND_MAX.
REQ-019 iss_rdy SHALL be 0 when count[iss_wa] == PEND_MAX, or when iss_wa == NREG-1; otherwise 1.
REQ-020 Accepted issue (iss_en & iss_rdy) SHALL increment count[iss_wa]; an issue with iss_rdy = 0 SHALL change no state.
REQ-021 Each of we0/we1 SHALL decrement its target count by one, saturating at 0; both to the same register SHALL decrement by 2, saturating at 0.
REQ-022 Simultaneous accepted issue and retire on one register SHALL apply the net change.
REQ-023 flush SHALL zero all counts on the next edge, overriding same-cycle issue; same-cycle writes SHALL still commit.
REQ-024 hazard SHALL be combinational: OR over ports k with re[k] & count[ra_k] > 0, except as relaxed by REQ-027.
REQ-025 Reset SHALL take priority over flush, issue and writes.

Reset
REQ-026 On reset, all registers SHALL become 0 and all counts SHALL become 0; iss_rdy = 1 and hazard = 0 in the first cycle after reset.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN, when defined:
- A read whose address matches an active write in the same cycle SHALL return that write data, with wd0 taking priority.
- A read SHALL not raise a hazard when its count would reach 0 after this cycle's retires.
REQ-028 Without REGFILE_BYPASS_EN, reads return pre-edge stored values, and the hazard rule of REQ-024 applies unrelaxed.

Structure
REQ-029 A shared package regfile_pkg SHALL hold AW derivation, the PC index constant, and the count type width clog2(PEND_MAX+1).
REQ-030 One sub-module, sb_counter (one saturating up/down pending counter), SHALL be instantiated NREG-1 times.

Verification
REQ-031 Reset, then read all ports at r3 with pc8 = 0x108: rd = 0 on each port; r15 read returns 0x108; hazard = 0.
REQ-032 Issue r4, then read r4 with re = 1: hazard = 1. Then write we0 r4 = 0xDEAD:
- with REGFILE_BYPASS_EN, rd = 0xDEAD and hazard = 0 in the same cycle;
- without it, hazard = 0 next cycle and rd = 0xDEAD.
REQ-033 Issue r2 three times (PEND_MAX = 3): iss_rdy = 0 on the next attempt and the count is unchanged. One retire, then issue: accepted.
REQ-034 we0 r5 = 0x11 and we1 r5 = 0x22 in the same cycle: r5 reads 0x11; count[r5] drops from 2 to 0.
REQ-035 Issue r6 and r7, then flush together with issue r8: all counts 0 next cycle; hazard = 0 for reads of r6, r7 and r8.
REQ-036 Pending r9 count 2, then assert reset together with iss_en: all counts 0 and register contents 0 after the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants and helpers for the scoreboarded register file.
//   aw_of(nreg)      : register address width, clog2(NREG)
//   pc_idx(nreg)     : index of the architectural PC register (NREG-1)
//   cnt_w(pend_max)  : width of a pending-write counter, clog2(PEND_MAX+1)
//   dec_t            : per-register retire amount (0, 1 or 2 writes per cycle)
package regfile_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int NREG_DEF     = 16;
  localparam int NRD_DEF      = 3;
  localparam int PEND_MAX_DEF = 3;

  function automatic int aw_of(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  function automatic int pc_idx(input int nreg);
    return nreg - 1;
  endfunction

  function automatic int cnt_w(input int pend_max);
    return (pend_max > 1) ? $clog2(pend_max + 1) : 1;
  endfunction

  typedef logic [1:0] dec_t;

endpackage

// File: rtl/sb_counter.sv
// sb_counter -- one pending-write counter of the register scoreboard.
//   clk   in  clock
//   reset in  synchronous active-high reset, clears the count
//   flush in  clears the count on the next edge, overriding inc/dec
//   inc   in  one accepted issue targets this register
//   dec   in  number of retiring writes (0..2) targeting this register
//   cnt   out current pending count 0..PEND_MAX
module sb_counter
  import regfile_pkg::*;
#(
  parameter int PEND_MAX = PEND_MAX_DEF,
  parameter int CW       = cnt_w(PEND_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          inc,
  input  dec_t          dec,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW+1:0] up;

  // Issue and retire in the same cycle apply as one net change, floored at 0.
  always_comb begin
    up = (CW+2)'(cnt_q) + (CW+2)'(inc);
    if (up > (CW+2)'(dec)) cnt_d = CW'(up - (CW+2)'(dec));
    else                   cnt_d = '0;
    if (int'(cnt_d) > PEND_MAX) cnt_d = CW'(PEND_MAX);
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with per-register pending-write scoreboard.
//   clk, reset          clock, synchronous active-high reset
//   ra/re               NRD read addresses (AW bits each) and enables
//   pc8                 value returned for reads of the PC register (NREG-1)
//   rd                  NRD read data slices (WIDTH bits each), combinational
//   we0/wa0/wd0         primary result write port (wins over port 1)
//   we1/wa1/wd1         base-writeback write port
//   iss_en/iss_wa       issue claim on a destination register
//   iss_rdy             claim would be accepted this cycle
//   flush               drop all pending claims
//   hazard              an enabled read targets a register with pending writes
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to reads and to suppress hazards that this cycle's retires resolve.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int NREG     = NREG_DEF,
  parameter  int NRD      = NRD_DEF,
  parameter  int PEND_MAX = PEND_MAX_DEF,
  localparam int AW       = aw_of(NREG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NRD*AW-1:0]  ra,
  input  logic [NRD-1:0]     re,
  input  logic [WIDTH-1:0]   pc8,
  output logic [NRD*WIDTH-1:0] rd,
  input  logic               we0,
  input  logic [AW-1:0]      wa0,
  input  logic [WIDTH-1:0]   wd0,
  input  logic               we1,
  input  logic [AW-1:0]      wa1,
  input  logic [WIDTH-1:0]   wd1,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_wa,
  output logic               iss_rdy,
  input  logic               flush,
  output logic               hazard
);

  localparam int PC = pc_idx(NREG);
  localparam int CW = cnt_w(PEND_MAX);

  // The PC is not stored; only r0..r(NREG-2) have storage and counters.
  logic [PC-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [PC-1:0][CW-1:0]    cnt;
  logic [PC-1:0]            inc;
  dec_t [PC-1:0]            dec;
  logic                     issue_ok;

  assign iss_rdy  = (int'(iss_wa) < PC) && (int'(cnt[iss_wa]) != PEND_MAX);
  assign issue_ok = iss_en & iss_rdy;

  always_comb begin
    for (int i = 0; i < PC; i++) begin
      inc[i] = issue_ok && (int'(iss_wa) == i);
      dec[i] = dec_t'(we0 && (int'(wa0) == i)) + dec_t'(we1 && (int'(wa1) == i));
    end
  end

  for (genvar g = 0; g < PC; g++) begin : g_cnt
    sb_counter #(.PEND_MAX(PEND_MAX), .CW(CW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .inc   (inc[g]),
      .dec   (dec[g]),
      .cnt   (cnt[g])
    );
  end

  // Port 1 is applied first so port 0 overwrites it on an address collision.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < PC; i++) begin
      if (we1 && (int'(wa1) == i)) regs_d[i] = wd1;
      if (we0 && (int'(wa0) == i)) regs_d[i] = wd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  always_comb begin
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] v;
    rd     = '0;
    hazard = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      a = ra[k*AW +: AW];
      v = '0;
      if (int'(a) == PC) begin
        v = pc8;
      end else if (int'(a) < PC) begin
        v = regs_q[a];
`ifdef REGFILE_BYPASS_EN
        if (we1 && (wa1 == a)) v = wd1;
        if (we0 && (wa0 == a)) v = wd0;
        // Hazard only if claims remain once this cycle's writes retire.
        if (re[k] && (int'(cnt[a]) > int'(dec[a]))) hazard = 1'b1;
`else
        if (re[k] && (cnt[a] != '0)) hazard = 1'b1;
`endif
      end
      rd[k*WIDTH +: WIDTH] = v;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int W  = 32;
  localparam int N  = 16;
  localparam int K  = 3;
  localparam int PM = 3;
  localparam int AW = 4;

  logic             clk;
  logic             reset;
  logic [K*AW-1:0]  ra;
  logic [K-1:0]     re;
  logic [W-1:0]     pc8;
  logic [K*W-1:0]   rd;
  logic             we0, we1;
  logic [AW-1:0]    wa0, wa1;
  logic [W-1:0]     wd0, wd1;
  logic             iss_en;
  logic [AW-1:0]    iss_wa;
  logic             iss_rdy;
  logic             flush;
  logic             hazard;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // Behavioural model: architectural values and pending-claim counts.
  int           m_cnt[N];
  logic [W-1:0] m_reg[N];

  regfile_sb dut (
    .clk(clk), .reset(reset), .ra(ra), .re(re), .pc8(pc8), .rd(rd),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_wa(iss_wa), .iss_rdy(iss_rdy),
    .flush(flush), .hazard(hazard)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_dec(input int r);
    return ((we0 && int'(wa0) == r) ? 1 : 0) + ((we1 && int'(wa1) == r) ? 1 : 0);
  endfunction

  function automatic logic [W-1:0] m_rd(input int k);
    int a;
    logic [W-1:0] v;
    a = int'(ra[k*AW +: AW]);
    if (a == N-1) return pc8;
    v = m_reg[a];
`ifdef REGFILE_BYPASS_EN
    if (we1 && int'(wa1) == a) v = wd1;
    if (we0 && int'(wa0) == a) v = wd0;
`endif
    return v;
  endfunction

  function automatic bit m_haz();
    int a;
    bit h;
    h = 0;
    for (int k = 0; k < K; k++) begin
      a = int'(ra[k*AW +: AW]);
      if (re[k] && a != N-1) begin
`ifdef REGFILE_BYPASS_EN
        if (m_cnt[a] - m_dec(a) > 0) h = 1;
`else
        if (m_cnt[a] > 0) h = 1;
`endif
      end
    end
    return h;
  endfunction

  function automatic bit m_rdy();
    return (int'(iss_wa) != N-1) && (m_cnt[iss_wa] < PM);
  endfunction

  // Advance one clock edge, applying the inputs present at that edge to the model.
  task automatic tick();
    bit acc;
    int c;
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < N; r++) begin m_cnt[r] = 0; m_reg[r] = '0; end
    end else begin
      acc = iss_en && m_rdy();
      for (int r = 0; r < N-1; r++) begin
        c = m_cnt[r] + ((acc && int'(iss_wa) == r) ? 1 : 0) - m_dec(r);
        m_cnt[r] = flush ? 0 : (c < 0 ? 0 : c);
      end
      if (we1 && int'(wa1) != N-1) m_reg[wa1] = wd1;
      if (we0 && int'(wa0) != N-1) m_reg[wa0] = wd0;
    end
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_en = 0; flush = 0; re = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < K; k++)
        chk($sformatf("cmp_rd%0d", k), rd[k*W +: W], m_rd(k));
      chk("cmp_hazard", W'(hazard), W'(m_haz()));
      chk("cmp_iss_rdy", W'(iss_rdy), W'(m_rdy()));
    end
  end

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 5));
  endfunction

  initial begin
    for (int r = 0; r < N; r++) begin m_cnt[r] = 0; m_reg[r] = '0; end
    reset = 1; ra = '0; pc8 = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_wa = '0;
    idle();
    tick(); tick();
    reset = 0;
    chk_en = 1;

    // Reset state, PC read
    ra = {4'd3, 4'd3, 4'd3}; re = 3'b111; pc8 = 32'h108;
    #2;
    for (int k = 0; k < K; k++) chk($sformatf("rst_rd%0d", k), rd[k*W +: W], 32'h0);
    chk("rst_hazard", W'(hazard), 32'h0);
    chk("rst_iss_rdy", W'(iss_rdy), 32'h1);
    ra = {4'd3, 4'd3, 4'd15};
    #1;
    chk("pc_read", rd[0 +: W], 32'h108);

    // Issue r4 then read it; retire with 0xDEAD
    idle(); iss_en = 1; iss_wa = 4;
    tick();
    idle(); ra = {4'd0, 4'd0, 4'd4}; re = 3'b001;
    #2;
    chk("haz_r4_pending", W'(hazard), 32'h1);
    chk("model_haz_r4", W'(m_haz()), 32'h1);
    we0 = 1; wa0 = 4; wd0 = 32'hDEAD;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd_r4", rd[0 +: W], 32'hDEAD);
    chk("byp_haz_r4", W'(hazard), 32'h0);
`endif
    tick();
    we0 = 0;
    #2;
    chk("haz_r4_retired", W'(hazard), 32'h0);
    chk("rd_r4_written", rd[0 +: W], 32'hDEAD);

    // Saturate r2 at PEND_MAX
    idle(); iss_en = 1; iss_wa = 2;
    for (int i = 0; i < 3; i++) begin
      #2; chk($sformatf("r2_rdy_%0d", i), W'(iss_rdy), 32'h1);
      tick();
    end
    #2; chk("r2_full_rdy", W'(iss_rdy), 32'h0);
    tick();
    #2; chk("r2_full_unchanged", W'(iss_rdy), 32'h0);
    chk("model_r2_cnt", W'(m_cnt[2]), 32'h3);
    iss_en = 0; we0 = 1; wa0 = 2; wd0 = 32'h22;
    tick();
    we0 = 0; iss_en = 1;
    #2; chk("r2_after_retire_rdy", W'(iss_rdy), 32'h1);
    tick();
    iss_en = 0;
    #2; chk("r2_full_again", W'(iss_rdy), 32'h0);

    // Dual write same register: wd0 wins, count drops by 2
    idle(); iss_en = 1; iss_wa = 5;
    tick(); tick();
    idle(); ra = {4'd0, 4'd0, 4'd5}; re = 3'b001;
    #2; chk("r5_pending", W'(hazard), 32'h1);
    we0 = 1; wa0 = 5; wd0 = 32'h11; we1 = 1; wa1 = 5; wd1 = 32'h22;
    tick();
    we0 = 0; we1 = 0;
    #2;
    chk("r5_wd0_wins", rd[0 +: W], 32'h11);
    chk("r5_cnt_zero", W'(hazard), 32'h0);

    // Flush overrides same-cycle issue
    idle(); iss_en = 1; iss_wa = 6; tick();
    iss_wa = 7; tick();
    idle(); ra = {4'd8, 4'd7, 4'd6}; re = 3'b111;
    #2; chk("r67_pending", W'(hazard), 32'h1);
    flush = 1; iss_en = 1; iss_wa = 8;
    tick();
    flush = 0; iss_en = 0;
    #2; chk("flush_haz", W'(hazard), 32'h0);

    // Reset wins over issue
    idle(); we0 = 1; wa0 = 9; wd0 = 32'h99; tick();
    we0 = 0; iss_en = 1; iss_wa = 9; tick(); tick();
    idle(); ra = {4'd4, 4'd0, 4'd9}; re = 3'b001;
    #2;
    chk("r9_pending", W'(hazard), 32'h1);
    chk("r9_value", rd[0 +: W], 32'h99);
    reset = 1; iss_en = 1; iss_wa = 9;
    tick();
    reset = 0; iss_en = 0;
    #2;
    chk("reset_r9_val", rd[0 +: W], 32'h0);
    chk("reset_r4_val", rd[2*W +: W], 32'h0);
    chk("reset_haz", W'(hazard), 32'h0);
    chk("reset_rdy", W'(iss_rdy), 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset  = ($urandom_range(0, 99) == 0);
      flush  = ($urandom_range(0, 31) == 0);
      iss_en = $urandom_range(0, 1) == 1;
      iss_wa = raddr();
      we0    = $urandom_range(0, 2) == 0;
      wa0    = raddr();
      wd0    = $urandom;
      we1    = $urandom_range(0, 3) == 0;
      wa1    = raddr();
      wd1    = $urandom;
      ra     = {raddr(), raddr(), raddr()};
      re     = 3'($urandom_range(0, 7));
      pc8    = $urandom;
    end
    tick();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
